// File: rtl/boid_frame_writer_if.sv
// Boid read port (BPU array) and framebuffer write port of the frame writer.
// master = frame writer, slave = BPU array / display RAM side.
interface boid_frame_writer_if #(
  parameter int BOID_BITS  = 7,
  parameter int ADDR_WIDTH = 19
);
  logic [BOID_BITS-1:0]  boid_sel;
  logic [9:0]            boid_x;
  logic [8:0]            boid_y;
  logic                  fb_we;
  logic [ADDR_WIDTH-1:0] fb_addr;
  logic                  fb_wdata;

  modport master (output boid_sel, fb_we, fb_addr, fb_wdata, input boid_x, boid_y);
  modport slave  (input boid_sel, fb_we, fb_addr, fb_wdata, output boid_x, boid_y);
endinterface

// File: rtl/boid_frame_writer.sv
// Renders one frame of boids into the back half of a double-buffered 1-bit framebuffer:
// clear, plot one pixel per on-screen boid, swap on the next frame_start.
module boid_frame_writer #(
  parameter int MAX_BOIDS    = 128,
  parameter int BOID_BITS    = 7,
  parameter int VIDEO_WIDTH  = 640,
  parameter int VIDEO_HEIGHT = 480,
  parameter int ADDR_WIDTH   = 19,
  parameter int CLEAR_ENABLE = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 frame_start,
  input  logic                 pause,
  boid_frame_writer_if.master  bus,
  output logic                 back_sel,
  output logic                 buf_swap,
  output logic                 busy,
  output logic [7:0]           overrun_cnt
);
  localparam int          P      = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int          DCNT_W = $clog2(MAX_BOIDS + 2);
  localparam logic [31:0] VW     = 32'(VIDEO_WIDTH);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} state_t;
  localparam state_t START = (CLEAR_ENABLE != 0) ? CLEAR : DRAW;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] ccnt;
  logic [DCNT_W-1:0]     dcnt;
  logic [1:0]            vld_pipe;  // [0]: boid_sel valid, [1]: boid_x/y valid
  logic                  go, clr_last, draw_last, sel_last, in_range;
  logic                  busy_d, swap_d, clr_we_d, draw_start, overrun_inc;

  // y*VIDEO_WIDTH + x as a sum of shifted y terms, one per set bit of the width
  function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [8:0] y, input logic [9:0] x);
    logic [ADDR_WIDTH-1:0] a;
    a = ADDR_WIDTH'(x);
    for (int b = 0; b < 32; b++)
      if (VW[b]) a = a + (ADDR_WIDTH'(y) << b);
    return a;
  endfunction

  assign go        = frame_start & ~pause;
  assign clr_last  = (ccnt == ADDR_WIDTH'(P - 1));
  assign draw_last = (dcnt == DCNT_W'(MAX_BOIDS + 1));
  assign sel_last  = (bus.boid_sel == BOID_BITS'(MAX_BOIDS - 1));
  assign in_range  = ({22'd0, bus.boid_x} < VW) && ({23'd0, bus.boid_y} < 32'(VIDEO_HEIGHT));

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go)        state_nx = START;
      CLEAR:   if (clr_last)  state_nx = DRAW;
      DRAW:    if (draw_last) state_nx = DONE;
      DONE:    if (go)        state_nx = START;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_d      = (state_nx == CLEAR) || (state_nx == DRAW);
    swap_d      = (state == DONE) && go;
    clr_we_d    = (state == CLEAR);
    draw_start  = (state_nx == DRAW) && (state != DRAW);
    overrun_inc = frame_start && ((state == CLEAR) || (state == DRAW)) && (overrun_cnt != 8'hFF);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy         <= 1'b0;
      buf_swap     <= 1'b0;
      back_sel     <= 1'b0;
      overrun_cnt  <= '0;
      ccnt         <= '0;
      dcnt         <= '0;
      vld_pipe     <= '0;
      bus.boid_sel <= '0;
      bus.fb_we    <= 1'b0;
      bus.fb_addr  <= '0;
      bus.fb_wdata <= 1'b0;
    end else begin
      busy     <= busy_d;
      buf_swap <= swap_d;
      back_sel <= back_sel ^ swap_d;
      if (overrun_inc) overrun_cnt <= overrun_cnt + 8'd1;
      ccnt <= (clr_we_d && !clr_last) ? ccnt + 1'b1 : '0;
      dcnt <= ((state == DRAW) && !draw_last) ? dcnt + 1'b1 : '0;

      // boid index issue; BPU answers one cycle later, write lands the cycle after that
      vld_pipe[1] <= vld_pipe[0];
      if (draw_start) begin
        vld_pipe[0]  <= 1'b1;
        bus.boid_sel <= '0;
      end else if (vld_pipe[0]) begin
        if (sel_last) begin
          vld_pipe[0]  <= 1'b0;
          bus.boid_sel <= '0;
        end else begin
          bus.boid_sel <= bus.boid_sel + 1'b1;
        end
      end

      if (clr_we_d) begin
        bus.fb_we    <= 1'b1;
        bus.fb_wdata <= 1'b0;
        bus.fb_addr  <= ccnt;
      end else if (vld_pipe[1] && in_range) begin
        bus.fb_we    <= 1'b1;
        bus.fb_wdata <= 1'b1;
        bus.fb_addr  <= pix_addr(bus.boid_y, bus.boid_x);
      end else begin
        bus.fb_we    <= 1'b0;
        bus.fb_wdata <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_boid_frame_writer.sv
// Scoreboard bench for boid_frame_writer on an 8x4 screen with 4 boids.
module tb_boid_frame_writer;
  logic       clock = 1'b0;
  logic       reset_n, frame_start, pause, back_sel, buf_swap, busy;
  logic [7:0] overrun_cnt;
  logic       fs2, pause2, back_sel2, buf_swap2, busy2;
  logic [7:0] overrun_cnt2;

  boid_frame_writer_if #(.BOID_BITS(2), .ADDR_WIDTH(5)) bus  ();
  boid_frame_writer_if #(.BOID_BITS(2), .ADDR_WIDTH(5)) bus2 ();

  boid_frame_writer #(.MAX_BOIDS(4), .BOID_BITS(2), .VIDEO_WIDTH(8), .VIDEO_HEIGHT(4),
                      .ADDR_WIDTH(5), .CLEAR_ENABLE(1)) dut (
    .clock(clock), .reset_n(reset_n), .frame_start(frame_start), .pause(pause), .bus(bus),
    .back_sel(back_sel), .buf_swap(buf_swap), .busy(busy), .overrun_cnt(overrun_cnt));

  boid_frame_writer #(.MAX_BOIDS(4), .BOID_BITS(2), .VIDEO_WIDTH(8), .VIDEO_HEIGHT(4),
                      .ADDR_WIDTH(5), .CLEAR_ENABLE(0)) dut2 (
    .clock(clock), .reset_n(reset_n), .frame_start(fs2), .pause(pause2), .bus(bus2),
    .back_sel(back_sel2), .buf_swap(buf_swap2), .busy(busy2), .overrun_cnt(overrun_cnt2));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // BPU array model: registered read of the selected boid
  logic [9:0] tbl_x [4];
  logic [8:0] tbl_y [4];
  always @(posedge clock) begin
    bus.boid_x  <= tbl_x[bus.boid_sel];
    bus.boid_y  <= tbl_y[bus.boid_sel];
    bus2.boid_x <= tbl_x[bus2.boid_sel];
    bus2.boid_y <= tbl_y[bus2.boid_sel];
  end

  typedef struct { int cyc; int addr; int data; } wr_t;
  typedef struct { int cyc; int sel; } sel_t;
  wr_t  wq[$];
  sel_t sq[$];
  int   n_chk = 0, n_fail = 0;
  bit   mon_en = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // monitor: compares every DUT write and boid_sel against the scoreboard queues
  always @(negedge clock) if (mon_en) begin
    if (wq.size() > 0 && wq[0].cyc == cyc) begin
      wr_t e;
      e = wq.pop_front();
      n_chk++;
      if (!(bus.fb_we === 1'b1 && int'(bus.fb_addr) == e.addr && int'(bus.fb_wdata) == e.data)) begin
        n_fail++;
        $display("FAIL write@cyc%0d: we=%0b addr=%0d data=%0b, expected addr=%0d data=%0d",
                 cyc, bus.fb_we, bus.fb_addr, bus.fb_wdata, e.addr, e.data);
      end
    end else if (bus.fb_we === 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL unexpected write@cyc%0d: addr=%0d data=%0b, expected no write",
               cyc, bus.fb_addr, bus.fb_wdata);
    end
    if (sq.size() > 0 && sq[0].cyc == cyc) begin
      sel_t s;
      s = sq.pop_front();
      n_chk++;
      if (int'(bus.boid_sel) != s.sel) begin
        n_fail++;
        $display("FAIL boid_sel@cyc%0d: got %0d, expected %0d", cyc, bus.boid_sel, s.sel);
      end
    end
  end

  // returns the cycle number at which the pulse is sampled (first cycle of the new state)
  task automatic pulse_fs(output int e);
    @(negedge clock);
    frame_start = 1'b1;
    e = cyc + 1;
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  task automatic expect_frame(input int e);
    for (int k = 0; k < 32; k++) wq.push_back('{e + 1 + k, k, 0});
    for (int i = 0; i < 4; i++) begin
      sq.push_back('{e + 32 + i, i});
      if (tbl_x[i] < 10'd8 && tbl_y[i] < 9'd4)
        wq.push_back('{e + 34 + i, int'(tbl_y[i]) * 8 + int'(tbl_x[i]), 1});
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin @(negedge clock); n++; end
    chk("busy timeout", int'(busy), 0);
  endtask

  task automatic set_tbl(input int sel);
    if (sel == 1) begin
      tbl_x = '{10'd1, 10'd7, 10'd2, 10'd0}; tbl_y = '{9'd0, 9'd3, 9'd1, 9'd0};
    end else begin
      tbl_x = '{10'd8, 10'd3, 10'd0, 10'd5}; tbl_y = '{9'd0, 9'd2, 9'd4, 9'd1};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, tmp, n, w;
    reset_n = 1'b0; frame_start = 1'b0; pause = 1'b0; fs2 = 1'b0; pause2 = 1'b0;
    set_tbl(1);
    repeat (3) @(negedge clock);
    chk("reset fb_we", int'(bus.fb_we), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset back_sel", int'(back_sel), 0);
    chk("reset buf_swap", int'(buf_swap), 0);
    chk("reset overrun_cnt", int'(overrun_cnt), 0);
    chk("reset boid_sel", int'(bus.boid_sel), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // frame 1: clear + four on-screen boids, no swap from IDLE
    pulse_fs(e);
    expect_frame(e);
    chk("swap from idle", int'(buf_swap), 0);
    chk("back_sel frame1", int'(back_sel), 0);
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clock); end
    chk("busy cycles", n, 38);
    repeat (3) @(negedge clock);

    // frame 2: swap from DONE, off-screen boids skipped, overrun during CLEAR
    set_tbl(2);
    pulse_fs(e);
    expect_frame(e);
    chk("swap pulse", int'(buf_swap), 1);
    chk("back_sel toggled", int'(back_sel), 1);
    @(negedge clock);
    chk("swap one cycle", int'(buf_swap), 0);
    repeat (3) @(negedge clock);
    pulse_fs(tmp);
    chk("overrun count 1", int'(overrun_cnt), 1);
    chk("no swap on overrun", int'(buf_swap), 0);
    chk("back_sel held", int'(back_sel), 1);
    wait_idle();
    repeat (4) @(negedge clock);
    chk("frame2 drained", wq.size() + sq.size(), 0);

    // overrun saturation
    mon_en = 1'b0;
    @(negedge clock);
    frame_start = 1'b1;
    repeat (300) @(negedge clock);
    frame_start = 1'b0;
    @(negedge clock);
    wait_idle();
    chk("overrun saturates", int'(overrun_cnt), 255);

    // asynchronous reset in the middle of DRAW
    set_tbl(1);
    pulse_fs(e);
    n = 0;
    while (cyc < e + 34 && n < 100) begin @(negedge clock); n++; end
    chk("we before reset", int'(bus.fb_we), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async fb_we", int'(bus.fb_we), 0);
    chk("async busy", int'(busy), 0);
    chk("async back_sel", int'(back_sel), 0);
    chk("async overrun", int'(overrun_cnt), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wq.delete(); sq.delete();
    mon_en = 1'b1;
    @(negedge clock);

    // first frame after reset starts from IDLE
    pulse_fs(e);
    expect_frame(e);
    chk("swap after reset", int'(buf_swap), 0);
    chk("back_sel after reset", int'(back_sel), 0);
    wait_idle();
    repeat (4) @(negedge clock);
    chk("frame3 drained", wq.size() + sq.size(), 0);

    // trails mode: pause blocks the start, then DRAW directly from IDLE
    pause2 = 1'b1;
    @(negedge clock); fs2 = 1'b1;
    @(negedge clock); fs2 = 1'b0;
    repeat (3) @(negedge clock);
    chk("pause ignores start", int'(busy2), 0);
    pause2 = 1'b0;
    @(negedge clock); fs2 = 1'b1;
    @(negedge clock); fs2 = 1'b0;
    n = 0; w = 0;
    while (busy2 && n < 100) begin
      n++;
      if (bus2.fb_we) w++;
      @(negedge clock);
    end
    chk("trails busy cycles", n, 6);
    chk("trails writes", w, 4);
    chk("trails back_sel", int'(back_sel2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
